// File: rtl/bench_bfm_arb_pkg.sv
// Shared types and helpers for the transaction-record channel arbiter.
package bench_bfm_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int MAX_AGENTS = 16;

  // Width of an agent index; a single-bit index is the floor.
  function automatic int agent_id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Round-robin pick: first set bit of req searching from ptr+1 upward, modulo n.
  // Returns ptr unchanged when req is empty.
  function automatic logic [3:0] rr_next(input logic [15:0] req,
                                         input logic [3:0]  ptr,
                                         input int          n);
    logic [3:0] g;
    logic       found;
    logic [4:0] idx;
    g     = ptr;
    found = 1'b0;
    for (int i = 1; i <= MAX_AGENTS; i++) begin
      idx = {1'b0, ptr} + 5'(i);
      if (idx >= 5'(n)) idx = idx - 5'(n);
      if (!found && (i <= n) && req[idx[3:0]]) begin
        g     = idx[3:0];
        found = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/bench_bfm_rr_pick.sv
// Combinational rotate-priority picker: lowest-priority slot is ptr_i.
module bench_bfm_rr_pick
  import bench_bfm_arb_pkg::*;
#(
  parameter int N_AGENTS = 4,
  parameter int ID_W     = agent_id_w(N_AGENTS)
) (
  input  logic [N_AGENTS-1:0] req_i,
  input  logic [ID_W-1:0]     ptr_i,
  output logic [ID_W-1:0]     gnt_idx_o,
  output logic                gnt_any_o
);

  logic [3:0] pick;

  // Search is done on a 16-wide view so the package helper serves any N_AGENTS.
  always_comb begin
    pick = rr_next(16'(req_i), 4'(ptr_i), N_AGENTS);
  end

  assign gnt_idx_o = ID_W'(pick);
  assign gnt_any_o = |req_i;

endmodule

// File: rtl/bench_bfm_txn_arbiter.sv
// Round-robin arbiter sharing one transaction-record channel between agent BFMs.
// Bursts are granted whole and forwarded with the agent index attached; a burst
// longer than MAX_BEATS is cut and the rest re-arbitrates as a new burst.
// Optional feature: define BFM_ARB_STATS_EN for per-agent completed-burst counters
// (stat_count, stat_clear, CNT_W).
module bench_bfm_txn_arbiter
  import bench_bfm_arb_pkg::*;
#(
  parameter int N_AGENTS  = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_BEATS = 16
`ifdef BFM_ARB_STATS_EN
  ,parameter int CNT_W    = 16
`endif
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_AGENTS-1:0]          agent_en,
  input  logic [N_AGENTS-1:0]          in_valid,
  output logic [N_AGENTS-1:0]          in_ready,
  input  logic [N_AGENTS*DATA_W-1:0]   in_data,
  input  logic [N_AGENTS-1:0]          in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_last,
  output logic [$clog2(N_AGENTS)-1:0]  out_agent_id,
  output logic                         busy,
  output logic                         trunc_pulse
`ifdef BFM_ARB_STATS_EN
  ,input  logic                        stat_clear,
  output logic [N_AGENTS*CNT_W-1:0]    stat_count
`endif
);

  localparam int ID_W = agent_id_w(N_AGENTS);
  localparam int BC_W = (MAX_BEATS < 2) ? 1 : $clog2(MAX_BEATS);
  localparam logic [BC_W-1:0] LAST_CNT = BC_W'(MAX_BEATS - 1);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] gnt_q, gnt_d;
  logic [BC_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;
  logic              g_valid, g_last;
  logic [DATA_W-1:0] g_data;

  bench_bfm_rr_pick #(
    .N_AGENTS (N_AGENTS),
    .ID_W     (ID_W)
  ) u_pick (
    .req_i     (in_valid & agent_en),
    .ptr_i     (rr_ptr_q),
    .gnt_idx_o (pick_idx),
    .gnt_any_o (pick_any)
  );

  // Select the granted agent's beat.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int n = 0; n < N_AGENTS; n++) begin
      if (gnt_q == ID_W'(n)) begin
        g_valid = in_valid[n];
        g_last  = in_last[n];
        g_data  = in_data[n*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and outputs; everything is quiet in IDLE.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    beat_cnt_d   = beat_cnt_q;
    in_ready     = '0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_last     = 1'b0;
    out_agent_id = '0;
    busy         = 1'b0;
    trunc_pulse  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d      = pick_idx;
          beat_cnt_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        busy         = 1'b1;
        out_valid    = g_valid;
        out_data     = g_data;
        out_agent_id = gnt_q;
        out_last     = g_last | (beat_cnt_q == LAST_CNT);
        for (int n = 0; n < N_AGENTS; n++) begin
          in_ready[n] = out_ready & (gnt_q == ID_W'(n));
        end
        if (out_valid && out_ready) begin
          if (out_last) begin
            state_d     = IDLE;
            rr_ptr_d    = gnt_q;
            beat_cnt_d  = '0;
            trunc_pulse = ~g_last;
          end else begin
            beat_cnt_d = beat_cnt_q + BC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; pointer resets to the last slot so agent 0 wins first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= ID_W'(N_AGENTS - 1);
      gnt_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef BFM_ARB_STATS_EN
  logic [N_AGENTS*CNT_W-1:0] stat_q;
  logic                      burst_done;

  assign burst_done = busy & out_valid & out_ready & out_last;

  // Saturating completed-burst counters; clear wins over a same-cycle increment.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_q <= '0;
    end else if (stat_clear) begin
      stat_q <= '0;
    end else begin
      for (int n = 0; n < N_AGENTS; n++) begin
        if (burst_done && (gnt_q == ID_W'(n)) &&
            (stat_q[n*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
          stat_q[n*CNT_W +: CNT_W] <= stat_q[n*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

  assign stat_count = stat_q;
`endif

endmodule

// File: tb/tb_bench_bfm_txn_arbiter.sv
// Scoreboard bench for bench_bfm_txn_arbiter (4 agents, 64-bit beats, 16-beat cap).
module tb_bench_bfm_txn_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   agent_en, in_valid, in_ready, in_last;
  logic [255:0] in_data;
  logic         out_valid, out_ready, out_last, busy, trunc_pulse;
  logic [63:0]  out_data;
  logic [1:0]   out_agent_id;
`ifdef BFM_ARB_STATS_EN
  logic         stat_clear;
  logic [7:0]   stat_count;
`endif

  bench_bfm_txn_arbiter #(
    .N_AGENTS  (4),
    .DATA_W    (64),
    .MAX_BEATS (16)
`ifdef BFM_ARB_STATS_EN
    ,.CNT_W    (2)
`endif
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .agent_en     (agent_en),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_agent_id (out_agent_id),
    .busy         (busy),
    .trunc_pulse  (trunc_pulse)
`ifdef BFM_ARB_STATS_EN
    ,.stat_clear  (stat_clear),
    .stat_count   (stat_count)
`endif
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [1:0]  id;
    logic [63:0] data;
    logic        last;
    logic        trunc;
    int          gap;
  } exp_t;

  beat_t      aq[4][$];
  exp_t       sb[$];
  logic [3:0] vmask;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         last_cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [63:0] mk(input int a, input int b, input int k);
    return {16'(a), 16'(b), 32'(k)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send(input int a, input int b, input int n, input bit end_last);
    beat_t bt;
    for (int k = 0; k < n; k++) begin
      bt.data = mk(a, b, k);
      bt.last = end_last && (k == n - 1);
      aq[a].push_back(bt);
    end
  endtask

  task automatic expect_beat(input int a, input int b, input int k,
                             input bit last, input bit trunc, input int gap);
    exp_t e;
    e.id = 2'(a); e.data = mk(a, b, k); e.last = last; e.trunc = trunc; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic wait_sb(input int n);
    int t = 0;
    do begin
      @(posedge clock); #1;
      t++;
    end while (sb.size() != n && t < 300);
    chk("wait_scoreboard_level", 64'(sb.size()), 64'(n));
  endtask

  task automatic wait_busy();
    int t = 0;
    do begin
      @(posedge clock); #1;
      t++;
    end while (!busy && t < 50);
    chk("wait_busy", 64'(busy), 64'(1));
  endtask

  task automatic wait_drain();
    int t = 0;
    int pend;
    do begin
      @(posedge clock); #1;
      t++;
      pend = sb.size() + aq[0].size() + aq[1].size() + aq[2].size() + aq[3].size();
    end while (pend != 0 && t < 300);
    chk("drain_pending", 64'(pend), 64'(0));
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    for (int n = 0; n < 4; n++) aq[n].delete();
    sb.delete();
    agent_en  = 4'hF;
    vmask     = 4'hF;
    out_ready = 1'b1;
`ifdef BFM_ARB_STATS_EN
    stat_clear = 1'b0;
`endif
    repeat (2) begin @(posedge clock); #1; end
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_trunc", 64'(trunc_pulse), 64'(0));
    chk("rst_agent_id", 64'(out_agent_id), 64'(0));
    chk("rst_out_data", out_data, 64'(0));
    reset = 1'b1;
  endtask

  // Agent BFMs: present the head beat of each queue, retire it on handshake.
  initial begin
    logic [3:0] fire;
    forever begin
      @(negedge clock); #4;
      fire = in_valid & in_ready;
      @(posedge clock); #2;
      for (int n = 0; n < 4; n++) begin
        if (fire[n] && aq[n].size() > 0) void'(aq[n].pop_front());
        if (aq[n].size() > 0 && vmask[n]) begin
          in_valid[n]            = 1'b1;
          in_data[n*64 +: 64]    = aq[n][0].data;
          in_last[n]             = aq[n][0].last;
        end else begin
          in_valid[n] = 1'b0;
          in_last[n]  = 1'b0;
        end
      end
    end
  end

  // Monitor: every beat about to be accepted downstream is checked against the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got id %0d data 0x%0h, expected no beat", out_agent_id, out_data);
        end else begin
          e = sb.pop_front();
          chk("beat_id", 64'(out_agent_id), 64'(e.id));
          chk("beat_data", out_data, e.data);
          chk("beat_last", 64'(out_last), 64'(e.last));
          chk("beat_trunc", 64'(trunc_pulse), 64'(e.trunc));
          if (e.gap != 0) chk("beat_gap", 64'(cyc - last_cyc), 64'(e.gap));
        end
        last_cyc = cyc;
      end else begin
        chk("idle_trunc", 64'(trunc_pulse), 64'(0));
      end
    end
  end

  initial begin
    reset     = 1'b0;
    agent_en  = 4'hF;
    vmask     = 4'hF;
    out_ready = 1'b1;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
`ifdef BFM_ARB_STATS_EN
    stat_clear = 1'b0;
`endif

    // 1: all agents, single-beat bursts -> 0,1,2,3,0 two cycles apart
    do_reset();
    send(0, 0, 1, 1); send(0, 1, 1, 1); send(1, 0, 1, 1); send(2, 0, 1, 1); send(3, 0, 1, 1);
    expect_beat(0, 0, 0, 1, 0, 0);
    expect_beat(1, 0, 0, 1, 0, 2);
    expect_beat(2, 0, 0, 1, 0, 2);
    expect_beat(3, 0, 0, 1, 0, 2);
    expect_beat(0, 1, 0, 1, 0, 2);
    wait_drain();

    // 2: agent 2 three-beat burst while 0/1 join -> 2,2,2 then 0 then 1
    do_reset();
    send(2, 0, 3, 1);
    expect_beat(2, 0, 0, 0, 0, 0);
    expect_beat(2, 0, 1, 0, 0, 1);
    expect_beat(2, 0, 2, 1, 0, 1);
    expect_beat(0, 0, 0, 1, 0, 2);
    expect_beat(1, 0, 0, 1, 0, 2);
    wait_busy();
    chk("t2_first_grant", 64'(out_agent_id), 64'(2));
    send(0, 0, 1, 1); send(1, 0, 1, 1);
    wait_drain();

    // 3: agent 1, 20 beats with last only on beat 20 -> forced cut at beat 16
    do_reset();
    send(1, 0, 20, 1);
    for (int k = 0; k < 20; k++)
      expect_beat(1, 0, k, (k == 15) || (k == 19), (k == 15),
                  (k == 0) ? 0 : ((k == 16) ? 2 : 1));
    wait_drain();

    // 4: enable and valid dropped mid-burst of agent 1
    do_reset();
    send(1, 0, 4, 1); send(1, 1, 1, 1); send(3, 0, 1, 1);
    expect_beat(1, 0, 0, 0, 0, 0);
    expect_beat(1, 0, 1, 0, 0, 0);
    expect_beat(1, 0, 2, 0, 0, 1);
    expect_beat(1, 0, 3, 1, 0, 1);
    expect_beat(3, 0, 0, 1, 0, 2);
    wait_sb(4);
    agent_en[1] = 1'b0;
    vmask[1]    = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      chk("t4_hold_busy", 64'(busy), 64'(1));
      chk("t4_hold_valid", 64'(out_valid), 64'(0));
      chk("t4_hold_id", 64'(out_agent_id), 64'(1));
    end
    vmask[1] = 1'b1;
    wait_sb(0);
    repeat (8) begin
      @(posedge clock); #1;
      chk("t4_disabled_no_grant", 64'(busy), 64'(0));
    end
    chk("t4_agent1_pending", 64'(aq[1].size()), 64'(1));
    expect_beat(1, 1, 0, 1, 0, 0);
    agent_en[1] = 1'b1;
    wait_drain();

    // 5: downstream stall, then reset mid-burst
    do_reset();
    send(2, 0, 3, 1);
    expect_beat(2, 0, 0, 0, 0, 0);
    expect_beat(2, 0, 1, 0, 0, 1);
    wait_busy();
    out_ready = 1'b0;
    send(0, 0, 1, 1);
    repeat (5) begin
      @(posedge clock); #1;
      chk("t5_stall_valid", 64'(out_valid), 64'(1));
      chk("t5_stall_data", out_data, mk(2, 0, 0));
      chk("t5_stall_ready", 64'(in_ready[2]), 64'(0));
      chk("t5_stall_busy", 64'(busy), 64'(1));
      chk("t5_stall_last", 64'(out_last), 64'(0));
    end
    out_ready = 1'b1;
    wait_sb(0);
    reset = 1'b0;
    #1;
    chk("t5_rst_busy", 64'(busy), 64'(0));
    chk("t5_rst_valid", 64'(out_valid), 64'(0));
    chk("t5_rst_ready", 64'(in_ready), 64'(0));
    expect_beat(0, 0, 0, 1, 0, 0);
    expect_beat(2, 0, 2, 1, 0, 2);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    wait_drain();

`ifdef BFM_ARB_STATS_EN
    // 6: completed-burst counters for agent 3, clear, then saturation
    do_reset();
    chk("t6_rst_stats", 64'(stat_count), 64'(0));
    for (int b = 0; b < 3; b++) begin
      send(3, b, 1, 1);
      expect_beat(3, b, 0, 1, 0, (b == 0) ? 0 : 2);
    end
    wait_drain();
    chk("t6_stat3_three", 64'(stat_count[7:6]), 64'(3));
    chk("t6_stat_others", 64'(stat_count[5:0]), 64'(0));
    stat_clear = 1'b1;
    @(posedge clock); #1;
    stat_clear = 1'b0;
    chk("t6_stat_cleared", 64'(stat_count), 64'(0));
    for (int b = 0; b < 5; b++) begin
      send(3, b, 1, 1);
      expect_beat(3, b, 0, 1, 0, (b == 0) ? 0 : 2);
    end
    wait_drain();
    chk("t6_stat3_saturated", 64'(stat_count[7:6]), 64'(3));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
